ktms_mmrd_mc_mwin_dec: RTL

Multi-window successor to the single-window multi-context MMIO read decoder. Decodes host MMIO read requests against up to nwin per-context address windows and issues one request to the selected backend. It tracks that request to completion with a response timeout, then returns a single-word or double-word muxed result to the MMIO return path. It sits between the PSL MMIO bus fan-out and the per-context register blocks.

---
 rtl/ktms_mmrd_mc_mwin_dec.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ktms_mmrd_mc_mwin_dec.sv
// ktms_mmrd_mc_mwin_dec
// Multi-window, multi-context MMIO read decoder. A host read that hits one of
// nwin address windows is forwarded to the backend once. The request is then
// tracked to a response, a cancel or a timeout. Single or double-word data is
// returned to the MMIO read path as a one-cycle pulse.
module ktms_mmrd_mc_mwin_dec #(
    parameter int addr_width    = 24,
    parameter int mmiobus_width = 4 + addr_width,
    parameter int ctxtid_width  = 10,
    parameter int ctxtid_start  = 14,
    parameter int lcladdr_width = 2,
    parameter int nwin          = 4,
    parameter logic [nwin*addr_width-1:0] win_base = '0,
    parameter int tmo_width     = 12,
    parameter int tmo_cycles    = 4000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [mmiobus_width-1:0] i_mmiobus,
    output logic                     o_rd_v,
    input  logic                     o_rd_r,
    output logic [nwin-1:0]          o_rd_win,
    output logic [lcladdr_width-1:0] o_rd_addr,
    output logic [ctxtid_width-1:0]  o_rd_ctxt,
    output logic                     i_rd_r,
    input  logic                     i_rd_v,
    input  logic                     i_rd_cancel,
    input  logic [63:0]              i_rd_d,
    output logic                     o_mmio_rd_v,
    output logic [63:0]              o_mmio_rd_d,
    output logic                     o_perror,
    output logic                     o_tmo,
    output logic                     o_overrun
);

    // Context id bits carried in the address (the parity bit is generated here).
    localparam int CTX_BITS = ctxtid_width - 1;
    // Lowest address bit above the context id; these upper bits are matched too.
    localparam int UP_LO    = ctxtid_start + ctxtid_width - 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [tmo_width-1:0] TMO_LAST = tmo_width'(tmo_cycles - 1);

    logic [addr_width-1:0]    bus_addr;
    logic                     bus_vld, bus_cfg, bus_rnw, bus_dw, rd_sel;
    logic [nwin-1:0]          hit, hit_oh;
    logic                     any_hit;
    logic [CTX_BITS-1:0]      bus_ctx;
    logic [ctxtid_width-1:0]  bus_ctxt;

    logic [1:0]               state_q, state_d;
    logic [tmo_width-1:0]     cnt_q, cnt_d;
    logic [nwin-1:0]          win_q;
    logic [lcladdr_width-1:0] lcl_q;
    logic [ctxtid_width-1:0]  ctxt_q;
    logic                     dw_q;
    logic [63:0]              data_q;
    logic                     tmo_q, perror_q, overrun_q;

    logic                     tmo_fire, to_tmo, rsp_take, parity_err;
    logic [31:0]              rsp_word;
    logic [63:0]              rsp_data;

    // Bus layout, msb first: {vld, cfg, rnw, dw, addr}.
    assign bus_addr = i_mmiobus[addr_width-1:0];
    assign bus_dw   = i_mmiobus[addr_width];
    assign bus_rnw  = i_mmiobus[addr_width+1];
    assign bus_cfg  = i_mmiobus[addr_width+2];
    assign bus_vld  = i_mmiobus[addr_width+3];
    assign rd_sel   = bus_vld & bus_rnw & ~bus_cfg;

    // Context id with an odd-parity bit appended in the lsb.
    assign bus_ctx  = bus_addr[ctxtid_start+CTX_BITS-1:ctxtid_start];
    assign bus_ctxt = {bus_ctx, ~^bus_ctx};

    // Per-window match: the context id bits are don't-care, everything else
    // above the local word address must equal the window base.
    for (genvar gi = 0; gi < nwin; gi++) begin : g_win
        localparam logic [addr_width-1:0] BASE = win_base[gi*addr_width +: addr_width];
        assign hit[gi] = rd_sel
            && (bus_addr[ctxtid_start-1:lcladdr_width] == BASE[ctxtid_start-1:lcladdr_width])
            && (bus_addr[addr_width-1:UP_LO] == BASE[addr_width-1:UP_LO]);
    end

    // Isolate the lowest set bit so overlapping windows resolve to the lowest k.
    assign hit_oh  = hit & (~hit + nwin'(1));
    assign any_hit = |hit;

    // A response accepted in the same cycle as the timeout takes precedence.
    assign tmo_fire   = ((state_q == S_REQ) || (state_q == S_WAIT)) && (cnt_q == TMO_LAST);
    assign to_tmo     = tmo_fire && !((state_q == S_WAIT) && i_rd_v);
    assign rsp_take   = (state_q == S_WAIT) && i_rd_v && !i_rd_cancel;
    // The counter is zero only in the first REQ cycle, which is when parity is checked.
    assign parity_err = (state_q == S_REQ) && (cnt_q == '0) && !(^ctxt_q);

    // Single-word reads use big-endian word order and replicate the word.
    assign rsp_word = lcl_q[0] ? i_rd_d[31:0] : i_rd_d[63:32];
    assign rsp_data = dw_q ? i_rd_d : {rsp_word, rsp_word};

    // Next-state and timeout counter selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = ((state_q == S_REQ) || (state_q == S_WAIT)) ? cnt_q + tmo_width'(1) : '0;
        case (state_q)
            S_IDLE: if (any_hit) state_d = S_REQ;
            S_REQ: begin
                if (tmo_fire)    state_d = S_RESP;
                else if (o_rd_r) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_rd_v)        state_d = i_rd_cancel ? S_IDLE : S_RESP;
                else if (tmo_fire) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state and timeout counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request fields on an accepted hit; they stay stable until the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_q  <= '0;
            lcl_q  <= '0;
            ctxt_q <= '0;
            dw_q   <= 1'b0;
        end else if ((state_q == S_IDLE) && any_hit) begin
            win_q  <= hit_oh;
            lcl_q  <= bus_addr[lcladdr_width-1:0];
            ctxt_q <= bus_ctxt;
            dw_q   <= bus_dw;
        end
    end

    // Return data register and timeout pulse, both aligned with the RESP cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            tmo_q <= to_tmo;
            if (rsp_take)    data_q <= rsp_data;
            else if (to_tmo) data_q <= '1;
        end
    end

    // Sticky error flags: bad context parity and hits that arrive while busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perror_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            perror_q  <= perror_q | parity_err;
            overrun_q <= overrun_q | (any_hit && (state_q != S_IDLE));
        end
    end

    assign o_rd_v      = (state_q == S_REQ);
    assign i_rd_r      = (state_q == S_WAIT);
    assign o_mmio_rd_v = (state_q == S_RESP);
    assign o_rd_win    = win_q;
    assign o_rd_addr   = lcl_q;
    assign o_rd_ctxt   = ctxt_q;
    assign o_mmio_rd_d = data_q;
    assign o_tmo       = tmo_q;
    assign o_perror    = perror_q;
    assign o_overrun   = overrun_q;

endmodule
